// File: rtl/wb_uart_tx_pkg.sv
// wb_uart_tx_pkg: register offsets, STATUS/CTRL bit positions and FSM state
// encoding shared by the Wishbone UART transmitter files.
package wb_uart_tx_pkg;

    // Register offsets, decoded on adr[3:2]
    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_DIV    = 2'd2;
    localparam logic [1:0] REG_CTRL   = 2'd3;

    // STATUS bit positions
    localparam int ST_EMPTY     = 0;
    localparam int ST_FULL      = 1;
    localparam int ST_BUSY      = 2;
    localparam int ST_OVERFLOW  = 3;
    localparam int ST_COUNT_LSB = 8;

    // CTRL bit positions
    localparam int CTRL_ENABLE = 0;
    localparam int CTRL_IRQ_EN = 1;
    localparam int CTRL_PARITY = 2;

    // Serializer states; PARITY is only reachable in parity-enabled builds
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_e;

endpackage

// File: rtl/wb_uart_tx_if.sv
// wb_uart_tx_if: Wishbone classic slave signals between the management SoC
// and the UART transmitter.
interface wb_uart_tx_if;

    logic        wbs_stb_i;
    logic        wbs_cyc_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_dat_i;
    logic [31:0] wbs_adr_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
        input  wbs_ack_o, wbs_dat_o
    );

    modport slave (
        input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
        output wbs_ack_o, wbs_dat_o
    );

endinterface

// File: rtl/wb_uart_tx_fifo.sv
// wb_uart_tx_fifo: synchronous FIFO with registered pointers and occupancy
// count. DEPTH must be a power of two so the pointers wrap naturally.
// A push while full is accepted only if a pop happens in the same cycle.
module wb_uart_tx_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      cnt_q;
    logic             do_push;
    logic             do_pop;

    assign full     = (cnt_q == (AW+1)'(DEPTH));
    assign empty    = (cnt_q == '0);
    assign count    = cnt_q;
    assign pop_data = mem[rd_ptr];

    // When full, wr_ptr aliases rd_ptr; the pop reads the old entry before
    // the edge overwrites it, so a simultaneous push+pop is safe.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    // Storage array, written on accepted pushes only
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
                2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/wb_uart_tx.sv
// wb_uart_tx: Wishbone-slave 8N1 UART transmitter driving user GPIO 32.
// Byte FIFO, programmable baud divider, level IRQ when the line drains.
// Optional parity bit (odd/even via CTRL[2]) when WB_UART_TX_PARITY_EN is
// defined; the default build sends 10-bit frames with no parity.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | line high; pops a byte when enabled and the FIFO is not empty
// START  | start bit (0) for one bit period
// DATA   | eight data bits, LSB first, bit_idx 0..7
// PARITY | parity bit for one bit period (parity build only)
// STOP   | stop bit (1); chains straight into START if more data waits
module wb_uart_tx #(
    parameter logic [31:0]      ADDR_BASE  = 32'h3000_0000,
    parameter int               FIFO_DEPTH = 8,
    parameter int               DIV_W      = 16,
    parameter logic [DIV_W-1:0] DIV_RST    = DIV_W'(434)
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    wb_uart_tx_if.slave   wbs,
    output logic          uart_tx_o,
    output logic          uart_oeb_o,
    output logic          irq_o
);

    import wb_uart_tx_pkg::*;

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    localparam logic [2:0] IDLE   = S_IDLE;
    localparam logic [2:0] START  = S_START;
    localparam logic [2:0] DATA   = S_DATA;
`ifdef WB_UART_TX_PARITY_EN
    localparam logic [2:0] PARITY = S_PARITY;
`endif
    localparam logic [2:0] STOP   = S_STOP;

    // Bus side
    logic             sel_hit;
    logic             acc;
    logic             wr;
    logic             ack_q;
    logic [31:0]      dat_q;
    logic [31:0]      rdata;

    // Configuration / status
    logic [DIV_W-1:0] div_q;
    logic             en_q;
    logic             irq_en_q;
    logic             odd_q;
    logic             ovf_q;

    // FIFO
    logic             push;
    logic             pop;
    logic [7:0]       fifo_dout;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;

    // Serializer
    logic [2:0]       state_q;
    logic [DIV_W-1:0] baud_cnt_q;
    logic [DIV_W-1:0] baud_reload;
    logic             baud_tc;
    logic [2:0]       bit_idx_q;
    logic [7:0]       data_q;
    logic             tx_q;
    logic             oeb_q;
    logic             irq_q;
    logic             busy;
    logic             can_start;

    logic             unused_bits;

    assign unused_bits = ^{wbs.wbs_adr_i[1:0], wbs.wbs_dat_i, wbs.wbs_sel_i};

    // A held strobe must see ack low for a cycle before the next access is
    // taken, so accesses are gated by the previous ack.
    assign sel_hit = wbs.wbs_cyc_i & wbs.wbs_stb_i
                   & (wbs.wbs_adr_i[31:4] == ADDR_BASE[31:4]);
    assign acc     = sel_hit & ~ack_q;
    assign wr      = acc & wbs.wbs_we_i;

    assign push    = wr & (wbs.wbs_adr_i[3:2] == REG_DATA) & wbs.wbs_sel_i[0];

    assign busy      = (state_q != IDLE);
    assign can_start = en_q & ~fifo_empty;
    assign baud_tc   = (baud_cnt_q == '0);
    // Bit period is max(DIV,1): count down from DIV-1 to zero.
    assign baud_reload = (div_q == '0) ? '0 : div_q - DIV_W'(1);
    assign pop = can_start & ((state_q == IDLE) | ((state_q == STOP) & baud_tc));

    wb_uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk       (wb_clk_i),
        .rst       (wb_rst_i),
        .push      (push),
        .push_data (wbs.wbs_dat_i[7:0]),
        .pop       (pop),
        .pop_data  (fifo_dout),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Read mux; the count field widens past bit 12 only for depths above 16.
    always_comb begin
        rdata = '0;
        case (wbs.wbs_adr_i[3:2])
            REG_STATUS: begin
                rdata[ST_EMPTY]                   = fifo_empty;
                rdata[ST_FULL]                    = fifo_full;
                rdata[ST_BUSY]                    = busy;
                rdata[ST_OVERFLOW]                = ovf_q;
                rdata[ST_COUNT_LSB +: CNT_W]      = fifo_count;
            end
            REG_DIV: begin
                rdata[DIV_W-1:0] = div_q;
            end
            REG_CTRL: begin
                rdata[CTRL_ENABLE] = en_q;
                rdata[CTRL_IRQ_EN] = irq_en_q;
                rdata[CTRL_PARITY] = odd_q;
            end
            default: rdata = '0;
        endcase
    end

    // Single-cycle ack pulse with read data valid only alongside it
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            ack_q <= 1'b0;
            dat_q <= '0;
        end else begin
            ack_q <= acc;
            dat_q <= acc ? rdata : '0;
        end
    end

    assign wbs.wbs_ack_o = ack_q;
    assign wbs.wbs_dat_o = dat_q;

    // Register writes on the ack edge, plus sticky overflow tracking
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            div_q    <= DIV_RST;
            en_q     <= 1'b0;
            irq_en_q <= 1'b0;
            odd_q    <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            if (push && fifo_full && !pop) begin
                ovf_q <= 1'b1;
            end
            if (wr) begin
                case (wbs.wbs_adr_i[3:2])
                    REG_STATUS: begin
                        if (wbs.wbs_sel_i[0] && wbs.wbs_dat_i[ST_OVERFLOW]) begin
                            ovf_q <= 1'b0;
                        end
                    end
                    REG_DIV: begin
                        for (int i = 0; i < DIV_W; i++) begin
                            if (wbs.wbs_sel_i[i/8]) begin
                                div_q[i] <= wbs.wbs_dat_i[i];
                            end
                        end
                    end
                    REG_CTRL: begin
                        if (wbs.wbs_sel_i[0]) begin
                            en_q     <= wbs.wbs_dat_i[CTRL_ENABLE];
                            irq_en_q <= wbs.wbs_dat_i[CTRL_IRQ_EN];
`ifdef WB_UART_TX_PARITY_EN
                            odd_q    <= wbs.wbs_dat_i[CTRL_PARITY];
`endif
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Frame serializer; the baud counter reloads on every state/bit entry
    // so a DIV change lands on the next bit boundary.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q    <= IDLE;
            baud_cnt_q <= '0;
            bit_idx_q  <= '0;
            data_q     <= '0;
            tx_q       <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    tx_q <= 1'b1;
                    if (pop) begin
                        data_q     <= fifo_dout;
                        state_q    <= START;
                        tx_q       <= 1'b0;
                        baud_cnt_q <= baud_reload;
                    end
                end
                START: begin
                    if (baud_tc) begin
                        state_q    <= DATA;
                        bit_idx_q  <= '0;
                        tx_q       <= data_q[0];
                        baud_cnt_q <= baud_reload;
                    end else begin
                        baud_cnt_q <= baud_cnt_q - DIV_W'(1);
                    end
                end
                DATA: begin
                    if (baud_tc) begin
                        baud_cnt_q <= baud_reload;
                        if (bit_idx_q == 3'd7) begin
`ifdef WB_UART_TX_PARITY_EN
                            state_q <= PARITY;
                            tx_q    <= (^data_q) ^ odd_q;
`else
                            state_q <= STOP;
                            tx_q    <= 1'b1;
`endif
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                            tx_q      <= data_q[bit_idx_q + 3'd1];
                        end
                    end else begin
                        baud_cnt_q <= baud_cnt_q - DIV_W'(1);
                    end
                end
`ifdef WB_UART_TX_PARITY_EN
                PARITY: begin
                    if (baud_tc) begin
                        state_q    <= STOP;
                        tx_q       <= 1'b1;
                        baud_cnt_q <= baud_reload;
                    end else begin
                        baud_cnt_q <= baud_cnt_q - DIV_W'(1);
                    end
                end
`endif
                STOP: begin
                    if (baud_tc) begin
                        if (pop) begin
                            data_q     <= fifo_dout;
                            state_q    <= START;
                            tx_q       <= 1'b0;
                            baud_cnt_q <= baud_reload;
                        end else begin
                            state_q <= IDLE;
                            tx_q    <= 1'b1;
                        end
                    end else begin
                        baud_cnt_q <= baud_cnt_q - DIV_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    tx_q    <= 1'b1;
                end
            endcase
        end
    end

    // Registered pad enable and drain interrupt
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            oeb_q <= 1'b1;
            irq_q <= 1'b0;
        end else begin
            oeb_q <= ~en_q;
            irq_q <= irq_en_q & fifo_empty & ~busy;
        end
    end

    assign uart_tx_o  = tx_q;
    assign uart_oeb_o = oeb_q;
    assign irq_o      = irq_q;

endmodule

// File: tb/tb_wb_uart_tx.sv
// tb_wb_uart_tx: randomized self-checking bench for wb_uart_tx. Expected line
// waveforms come from a frame-level model (level, duration) of each bit.
// Honours WB_UART_TX_PARITY_EN when defined for both bench and design.
`timescale 1ns/1ps
module tb_wb_uart_tx;

    localparam logic [31:0] BASE  = 32'h3000_0000;
    localparam int          DEPTH = 8;
`ifdef WB_UART_TX_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic uart_tx;
    logic uart_oeb;
    logic irq;

    wb_uart_tx_if bus();

    wb_uart_tx #(
        .ADDR_BASE  (BASE),
        .FIFO_DEPTH (DEPTH),
        .DIV_W      (16),
        .DIV_RST    (16'd434)
    ) dut (
        .wb_clk_i   (clk),
        .wb_rst_i   (rst),
        .wbs        (bus),
        .uart_tx_o  (uart_tx),
        .uart_oeb_o (uart_oeb),
        .irq_o      (irq)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Line/irq trace sampled mid-cycle
    bit rec = 1'b0;
    bit tr_tx[$];
    bit tr_irq[$];

    always @(negedge clk) begin
        if (rec) begin
            tr_tx.push_back(uart_tx);
            tr_irq.push_back(irq);
        end
    end

    // Frame model: each entry is a line level held for a number of cycles
    int exp_lv[$];
    int exp_du[$];

    function automatic void add_frame(input logic [7:0] b, input int div, input bit par, input bit odd);
        int d;
        d = (div < 1) ? 1 : div;
        exp_lv.push_back(0);
        exp_du.push_back(d);
        for (int i = 0; i < 8; i++) begin
            exp_lv.push_back(int'(b[i]));
            exp_du.push_back(d);
        end
        if (par) begin
            exp_lv.push_back(int'((^b) ^ odd));
            exp_du.push_back(d);
        end
        exp_lv.push_back(1);
        exp_du.push_back(d);
    endfunction

    function automatic int exp_total();
        int t;
        t = 0;
        foreach (exp_du[i]) t += exp_du[i];
        return t;
    endfunction

    function automatic logic irq_at(input int i);
        if (i >= 0 && i < tr_irq.size()) return tr_irq[i];
        return 1'bx;
    endfunction

    task automatic start_rec();
        tr_tx.delete();
        tr_irq.delete();
        exp_lv.delete();
        exp_du.delete();
        rec = 1'b1;
    endtask

    task automatic check_trace(input string tag, output int end_idx);
        int idx;
        int ok;
        idx = -1;
        foreach (tr_tx[i]) if (idx < 0 && tr_tx[i] == 1'b0) idx = i;
        check({tag, " start"}, (idx >= 0), 1);
        if (idx < 0) begin
            end_idx = -1;
            return;
        end
        for (int k = 0; k < exp_lv.size(); k++) begin
            ok = 0;
            for (int j = 0; j < exp_du[k]; j++) begin
                if (idx + j < tr_tx.size() && int'(tr_tx[idx + j]) == exp_lv[k]) ok++;
            end
            check($sformatf("%s bit%0d cycles", tag, k), ok, exp_du[k]);
            idx += exp_du[k];
        end
        check({tag, " idle after"}, (idx < tr_tx.size()) ? 32'(tr_tx[idx]) : 32'hx, 1);
        end_idx = idx;
    endtask

    task automatic bus_idle();
        bus.wbs_cyc_i = 1'b0;
        bus.wbs_stb_i = 1'b0;
        bus.wbs_we_i  = 1'b0;
        bus.wbs_sel_i = 4'h0;
        bus.wbs_dat_i = 32'h0;
        bus.wbs_adr_i = 32'h0;
    endtask

    task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s = 4'hF);
        int n;
        n = 0;
        @(posedge clk); #1;
        bus.wbs_cyc_i = 1'b1;
        bus.wbs_stb_i = 1'b1;
        bus.wbs_we_i  = 1'b1;
        bus.wbs_sel_i = s;
        bus.wbs_dat_i = d;
        bus.wbs_adr_i = a;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!bus.wbs_ack_o && n < 16);
        check($sformatf("wr ack @%0h", a), bus.wbs_ack_o, 1);
        bus_idle();
    endtask

    task automatic wb_read(input logic [31:0] a, output logic [31:0] d);
        int n;
        n = 0;
        @(posedge clk); #1;
        bus.wbs_cyc_i = 1'b1;
        bus.wbs_stb_i = 1'b1;
        bus.wbs_we_i  = 1'b0;
        bus.wbs_sel_i = 4'hF;
        bus.wbs_adr_i = a;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!bus.wbs_ack_o && n < 16);
        check($sformatf("rd ack @%0h", a), bus.wbs_ack_o, 1);
        d = bus.wbs_dat_o;
        bus_idle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, vectors=%0d", n_vec);
        $fatal(1);
    end

    initial begin
        logic [31:0] d;
        logic [7:0]  bytes[$];
        int          e;
        int          acks;
        int          n;
        int          div;
        bit          odd;
        bit          ien;
        bit          seen;

        bus_idle();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst tx", uart_tx, 1);
        check("rst oeb", uart_oeb, 1);
        check("rst irq", irq, 0);
        check("rst ack", bus.wbs_ack_o, 0);
        check("rst dat", bus.wbs_dat_o, 0);
        rst = 1'b0;
        wb_read(BASE + 32'h4, d); check("rst status", d, 32'h1);
        wb_read(BASE + 32'h8, d); check("rst div", d, 434);
        wb_read(BASE + 32'hC, d); check("rst ctrl", d, 0);
        wb_read(BASE + 32'h0, d); check("data reads 0", d, 0);

        // Held strobe on STATUS: ack on every second cycle
        @(posedge clk); #1;
        bus.wbs_cyc_i = 1'b1;
        bus.wbs_stb_i = 1'b1;
        bus.wbs_sel_i = 4'hF;
        bus.wbs_adr_i = BASE + 32'h4;
        for (int c = 1; c <= 6; c++) begin
            if (c > 1) begin
                @(posedge clk); #1;
            end
            check($sformatf("held ack c%0d", c), bus.wbs_ack_o, (c % 2 == 0));
            check($sformatf("held dat c%0d", c), bus.wbs_dat_o, (c % 2 == 0) ? 32'h1 : 32'h0);
        end
        bus_idle();
        @(posedge clk); #1;
        bus.wbs_cyc_i = 1'b1;
        bus.wbs_stb_i = 1'b1;
        bus.wbs_sel_i = 4'hF;
        bus.wbs_adr_i = BASE + 32'h10;
        acks = 0;
        repeat (6) begin
            @(posedge clk); #1;
            acks += int'(bus.wbs_ack_o);
        end
        bus_idle();
        check("unmapped acks", acks, 0);

        // DIV byte select: only the low byte changes
        wb_write(BASE + 32'h8, 32'h0000_FFFF, 4'b0001);
        wb_read(BASE + 32'h8, d); check("div sel0", d, 32'h1FF);

        // Single frame 0xA5 at DIV=4, irq disabled
        wb_write(BASE + 32'h8, 4);
        wb_write(BASE + 32'hC, 1);
        start_rec();
        wb_write(BASE + 32'h0, 32'hA5);
        wb_read(BASE + 32'h4, d); check("a5 status busy", d, 32'h5);
        add_frame(8'hA5, 4, PAR, 1'b0);
        repeat (exp_total() + 12) @(posedge clk);
        rec = 1'b0;
        check_trace("a5", e);
        acks = 0;
        foreach (tr_irq[i]) acks += int'(tr_irq[i]);
        check("a5 irq low", acks, 0);
        check("oeb enabled", uart_oeb, 0);

        // Back-to-back frames with irq on drain
        wb_write(BASE + 32'h8, 2);
        wb_write(BASE + 32'hC, 2);
        wb_write(BASE + 32'h0, 32'h01);
        wb_write(BASE + 32'h0, 32'h80);
        start_rec();
        wb_write(BASE + 32'hC, 3);
        add_frame(8'h01, 2, PAR, 1'b0);
        add_frame(8'h80, 2, PAR, 1'b0);
        repeat (exp_total() + 15) @(posedge clk);
        rec = 1'b0;
        check_trace("b2b", e);
        check("b2b irq at stop end", irq_at(e), 0);
        check("b2b irq rise", irq_at(e + 1), 1);
        wb_read(BASE + 32'h4, d); check("b2b status", d, 32'h1);

        // Randomized bursts: random divider (incl. 0), bytes, parity sense
        for (int r = 0; r < 6; r++) begin
            n   = $urandom_range(1, 4);
            div = $urandom_range(0, 3);
            odd = 1'($urandom_range(0, 1));
            ien = 1'($urandom_range(0, 1));
            wb_write(BASE + 32'h8, div);
            wb_write(BASE + 32'hC, {29'h0, odd, ien, 1'b0});
            bytes.delete();
            for (int i = 0; i < n; i++) begin
                bytes.push_back(8'($urandom));
                wb_write(BASE + 32'h0, {24'h0, bytes[i]});
            end
            wb_read(BASE + 32'hC, d);
            check($sformatf("rnd%0d ctrl", r), d, {29'h0, odd & PAR, ien, 1'b0});
            start_rec();
            wb_write(BASE + 32'hC, {29'h0, odd, ien, 1'b1});
            foreach (bytes[i]) add_frame(bytes[i], div, PAR, odd);
            repeat (exp_total() + 20) @(posedge clk);
            rec = 1'b0;
            check_trace($sformatf("rnd%0d", r), e);
            check($sformatf("rnd%0d irq", r), irq_at(e + 1), ien);
            wb_read(BASE + 32'h4, d); check($sformatf("rnd%0d status", r), d, 32'h1);
        end

`ifdef WB_UART_TX_PARITY_EN
        // Odd parity, DIV=1, 0x07 -> parity bit 0, 11-bit frame
        wb_write(BASE + 32'h8, 1);
        wb_write(BASE + 32'hC, 4);
        wb_write(BASE + 32'h0, 32'h07);
        start_rec();
        wb_write(BASE + 32'hC, 5);
        add_frame(8'h07, 1, 1'b1, 1'b1);
        repeat (exp_total() + 12) @(posedge clk);
        rec = 1'b0;
        check_trace("par07", e);
`endif

        // Overflow: nine bytes into an eight-entry FIFO while disabled
        wb_write(BASE + 32'hC, 0);
        bytes.delete();
        for (int i = 0; i < DEPTH + 1; i++) begin
            bytes.push_back(8'($urandom));
            wb_write(BASE + 32'h0, {24'h0, bytes[i]});
        end
        wb_read(BASE + 32'h4, d); check("ovf status", d, 32'h80A);
        wb_write(BASE + 32'h4, 32'h8);
        wb_read(BASE + 32'h4, d); check("ovf cleared", d, 32'h802);

        // Reset during data bit 3 of the first queued byte
        wb_write(BASE + 32'h8, 4);
        wb_write(BASE + 32'hC, 1);
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            if (uart_tx == 1'b0) seen = 1'b1;
        end
        check("rst-test start seen", uart_tx, 0);
        repeat (17) @(negedge clk);
        check("pre-rst bit3", uart_tx, bytes[0][3]);
        rst = 1'b1;
        @(posedge clk); #1;
        check("mid rst tx", uart_tx, 1);
        check("mid rst oeb", uart_oeb, 1);
        check("mid rst irq", irq, 0);
        rst = 1'b0;
        wb_read(BASE + 32'h4, d); check("post rst status", d, 32'h1);
        wb_read(BASE + 32'h8, d); check("post rst div", d, 434);
        wb_read(BASE + 32'hC, d); check("post rst ctrl", d, 0);
        check("post rst tx idle", uart_tx, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/wb_uart_tx.md
Name: wb_uart_tx

Overview:
- Wishbone-slave UART transmitter instantiated in the user wrapper beside the user project.
- Consumes firmware Wishbone writes from the management SoC and drives one user GPIO pad: io_out/io_oeb bit 32, directly below the example block's 37:33 slice.
- Contains a byte FIFO, a programmable baud divider and an 8N1 serializer (parity optional).
- Raises a user IRQ when the transmitter drains.

Parameters:
- ADDR_BASE, 32'h3000_0000: register window base; decode is on adr[31:4].
- FIFO_DEPTH, 8: TX FIFO entries; must be a power of 2, range 2..64.
- DIV_W, 16: baud divider width.
- DIV_RST, 16'd434: divider reset value (115200 baud at 50 MHz).

Ports:
- wb_clk_i  in  1  clock, all logic.
- wb_rst_i  in  1  synchronous reset, active-high.
- wbs_stb_i  in  1  Wishbone strobe.
- wbs_cyc_i  in  1  Wishbone cycle.
- wbs_we_i  in  1  write enable.
- wbs_sel_i  in  4  byte selects.
- wbs_dat_i  in  32  write data.
- wbs_adr_i  in  32  byte address.
- wbs_ack_o  out  1  acknowledge.
- wbs_dat_o  out  32  read data.
- uart_tx_o  out  1  serial line; drives io_out[32].
- uart_oeb_o  out  1  pad output-enable-bar; drives io_oeb[32].
- irq_o  out  1  drives user_irq[0].

Behaviour:
- Reset values:
  - wbs_ack_o=0, wbs_dat_o=0.
  - uart_tx_o=1, uart_oeb_o=1, irq_o=0.
  - FIFO empty, overflow flag=0, DIV=DIV_RST, CTRL=0, FSM=IDLE.
- Register map (offsets adr[3:2]):
  - 0x0 DATA (WO): a write with sel[0]=1 pushes dat[7:0]. Reads return 0.
  - 0x4 STATUS (RO, except bit3):
    - bit0 empty, bit1 full, bit2 busy (FSM not IDLE), bit3 overflow (sticky).
    - bits[12:8] FIFO count.
    - Writing 1 to bit3 clears overflow.
  - 0x8 DIV (RW): [DIV_W-1:0]; byte selects honoured.
  - 0xC CTRL (RW): bit0 enable, bit1 irq_en, bit2 parity_odd (exists only with the option).
- Wishbone handshake:
  - Selected when cyc&stb and adr[31:4]==ADDR_BASE[31:4]. Unselected addresses are never acked.
  - ack is a 1-cycle pulse in the cycle after selection, with ack forced low in the cycle following an ack. A held stb therefore yields ack every 2nd cycle.
  - Writes take effect on the ack edge. wbs_dat_o is valid with ack and 0 otherwise.
- FIFO rules:
  - Push when full with no same-cycle pop: byte dropped, overflow=1.
  - Push and pop in the same cycle when full: both succeed, count unchanged.
- Pad control: uart_oeb_o = ~CTRL.enable, registered.
- Baud tick: bit period = max(DIV,1) clock cycles. The counter reloads at each state entry.
- FSM: IDLE -> START -> DATA -> STOP -> IDLE.
  - IDLE: tx=1. If enable & !empty, pop the byte into the shift register and go to START.
  - START: tx=0 for 1 bit period.
  - DATA: 8 bits, LSB first, bit counter 0..7.
  - STOP: tx=1 for 1 bit period. Then, if enable & !empty, pop and go to START directly (back-to-back frames, no idle gap). Otherwise go to IDLE.
- Clearing enable mid-frame: the current frame completes; no further pop occurs.
- DIV written mid-frame: applies from the next bit.
- Reset mid-frame: tx=1 on the next edge and the FIFO is flushed.
- irq_o = irq_en & empty & ~busy, registered (1-cycle latency), level-sensitive.

Optional Feature:
- Macro: WB_UART_TX_PARITY_EN.
- Defined:
  - CTRL bit2 is implemented (0 = even, 1 = odd).
  - A PARITY state is inserted between DATA and STOP, one bit period long.
  - Parity bit = XOR of the data bits, XOR parity_odd.
  - Frame length is 11 bits.
- Undefined:
  - CTRL bit2 reads 0 and ignores writes.
  - No PARITY state exists; frames are 10 bits.

Decomposition:
- Package wb_uart_tx_pkg holds:
  - register offsets (REG_DATA/STATUS/DIV/CTRL);
  - STATUS and CTRL bit indices;
  - the FSM state enum (IDLE, START, DATA, PARITY, STOP).
- One sub-module, wb_uart_tx_fifo: synchronous FIFO with push/pop/full/empty/count, parameterised on depth and width.
- Bus decode and FSM stay in the top.

Test Plan:
- Reset, DIV=4, CTRL=1, write DATA=0xA5 -> tx sequence 0,1,0,1,0,0,1,0,1,1, each level held exactly 4 cycles; busy=1 during the frame; irq_o=0 since irq_en=0.
- CTRL=3, DIV=2, write 0x01 then 0x80 -> two frames back-to-back with no idle gap; irq_o rises 1 cycle after the second stop bit ends; STATUS reads 0x1.
- CTRL=0, write 9 bytes (FIFO_DEPTH=8) -> STATUS = full=1, overflow=1, count=8; write 0x8 to STATUS -> overflow clears, full stays 1.
- Held stb on STATUS for 6 cycles -> ack on cycles 2, 4, 6; an access at ADDR_BASE+0x10 -> no ack.
- Assert wb_rst_i during DATA bit 3 -> tx=1 and oeb=1 on the next edge, STATUS reads empty, DIV reads 434.
- Parity option defined, CTRL=5, DIV=1, write 0x07 -> parity bit 0 (odd parity, three 1s), frame is 11 bits long.
